ibus_responder: RTL
===================

Name: ibus_responder

Overview:
- Instruction-port responder (target side) for the merlin32i fetch bus. It accepts ireq* requests from the prefetch unit and returns irsp* responses in order.
- Backed by an internal synchronous-read word RAM, with address-range, alignment and privilege checking.
- A side-band loader write port lets the bench or debug logic fill the memory.
- Sits between the core's instruction port and the system; it is the standard fetch target for simulation and FPGA builds.

Parameters:
- C_MEM_SZX, 10, log2 of RAM depth in 32-bit words (1024 words).
- C_BASE_ADDR, 32'h00000000, byte address of word 0; must be aligned to the RAM size.
- C_FIFO_DEPTH_X, 2, log2 of response FIFO depth (4 entries).
- C_USER_BASE, 32'h00000200, lowest byte address fetchable when hpl==2'b00 (user).

Ports:
- clk_i  in  1  clock.
- resetb_i  in  1  asynchronous active-low reset.
- clk_en_i  in  1  global clock enable; when 0, nothing updates.
- ireqready_o  out  1  responder can accept a request.
- ireqvalid_i  in  1  request valid.
- ireqhpl_i  in  2  hart privilege level of the request.
- ireqaddr_i  in  32  fetch byte address.
- irspready_i  in  1  core accepts the response.
- irspvalid_o  out  1  response valid.
- irsprerr_o  out  1  fetch error for this response.
- irspdata_o  out  32  instruction word.
- ld_wr_i  in  1  loader write strobe.
- ld_addr_i  in  C_MEM_SZX  loader word index.
- ld_data_i  in  32  loader write data.

Behaviour:
- Clock and reset: single clock clk_i; reset resetb_i is asynchronous, active-low.
- Reset values:
  - ireqready_o=0 while resetb_i=0, and 1 from the first enabled edge after release.
  - irspvalid_o=0, irsprerr_o=0, irspdata_o=0.
  - Outstanding counter=0, S1 stage and FIFO empty.
  - RAM contents are not reset.
- Handshakes:
  - Request accepted on an edge where clk_en_i & ireqvalid_i & ireqready_o.
  - Response consumed on an edge where clk_en_i & irspvalid_o & irspready_i.
  - With clk_en_i=0, no state, counter or RAM changes occur.
- Flow control:
  - ireqready_o = (outstanding < 2**C_FIFO_DEPTH_X).
  - outstanding: +1 on accept, -1 on consume, unchanged if both happen on the same edge.
  - ireqready_o is a registered or count-only function; there is no combinational path from irspready_i.
- Pipeline:
  - An accepted request reads the RAM at edge k.
  - The S1 register holds {valid, rerr, data} from edge k.
  - irspvalid_o=1 in the cycle after edge k (minimum latency 1 cycle).
  - Output mux: FIFO head if the FIFO is non-empty, else S1.
  - If S1 is not consumed, it is pushed into the FIFO on the next edge, which may coincide with a new S1 load.
  - Responses are strictly in request order.
- Error checks, evaluated at acceptance:
  - misaligned: ireqaddr_i[1:0]!=0.
  - out of range: (ireqaddr_i - C_BASE_ADDR) >= 4*2**C_MEM_SZX, using unsigned 32-bit wrap arithmetic.
  - privilege: ireqhpl_i==2'b00 and ireqaddr_i < C_USER_BASE.
  - Any error gives irsprerr_o=1 and irspdata_o=32'h0. The request still consumes a credit and returns exactly one response.
- Loader:
  - ld_wr_i writes the RAM at the edge it is sampled (when clk_en_i=1).
  - Same-edge loader write and fetch read of the same word returns the old data (read-first).
- FIFO boundaries:
  - The FIFO never overflows, because credits bound occupancy: S1 + FIFO ≤ 2**C_FIFO_DEPTH_X.
  - Empty: the output falls through from S1.
  - Pointers wrap modulo depth with a separate count; no full/empty ambiguity.
- Reset mid-operation: in-flight requests and queued responses are discarded with no response; the RAM is preserved.

Decomposition:
- Shared package/defines file (riscv_defs.v):
  - HPL encodings (HPL_USER=2'b00, HPL_MACHINE=2'b11).
  - IBUS response field range macros.
- One sub-module: ibus_rsp_fifo, a synchronous FIFO of {rerr, data}, 33 bits wide, depth 2**C_FIFO_DEPTH_X, with count output.
- The RAM is inferred inline.

Test Plan:
1. Basic fetch:
   - Load word 3 = 32'h00500093 via loader.
   - Request addr 32'h0000000C, hpl=2'b11, irspready_i=1.
   - Expect irspvalid_o=1 one cycle after accept, data=32'h00500093, rerr=0.
2. Back-to-back streaming:
   - Requests to 0x0, 0x4, 0x8, 0xC on consecutive cycles with irspready_i=1.
   - Expect 4 consecutive in-order responses matching RAM, ireqready_o continuously 1.
3. Backpressure:
   - irspready_i=0, ireqvalid_i=1 held.
   - Expect exactly 4 accepts, then ireqready_o=0.
   - Raise irspready_i; expect 4 in-order responses, and ireqready_o returns to 1 on the edge after the first consume.
4. Errors:
   - addr 32'h00000002 → rerr=1, data=0.
   - addr 32'h00001000 (C_MEM_SZX=10) → rerr=1.
   - hpl=2'b00 addr 32'h00000100 → rerr=1.
   - hpl=2'b00 addr 32'h00000200 → rerr=0.
5. Clock enable and reset:
   - clk_en_i=0 for 3 cycles during a pending response → outputs frozen, no handshake counted.
   - Assert resetb_i with 2 responses queued → irspvalid_o=0 immediately.
   - After release, fetch of word 3 still returns 32'h00500093.
6. Loader collision: loader writes word 5=32'hDEADBEEF on the same edge a fetch of 0x14 is accepted → response returns the old word; a second fetch returns 32'hDEADBEEF.

Source files
------------

// File: rtl/ibus_responder_pkg.sv
// Shared types and helpers for the merlin32i instruction-bus responder.
// Holds the privilege encodings, the response record and the fetch fault rule.
package ibus_responder_pkg;

    typedef enum logic [1:0] {
        HPL_USER    = 2'b00,
        HPL_MACHINE = 2'b11
    } hpl_e;

    typedef struct packed {
        logic        rerr;
        logic [31:0] data;
    } ibus_rsp_t;

    // A fetch faults when it is misaligned, outside the RAM window, or a user fetch below the user base.
    function automatic logic fetch_fault(
        input logic [31:0] addr,
        input logic [1:0]  hpl,
        input logic [31:0] base,
        input logic [31:0] user_base,
        input int          szx
    );
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00)
            || ((off >> (szx + 2)) != 32'd0)
            || ((hpl == HPL_USER) && (addr < user_base));
    endfunction

endpackage

// File: rtl/ibus_responder_rsp_fifo.sv
// Synchronous response FIFO of {rerr, data}; occupancy is bounded upstream by credits.
// Pointers wrap modulo depth and a separate count removes full/empty ambiguity.
module ibus_rsp_fifo
    import ibus_responder_pkg::*;
#(
    parameter int C_FIFO_DEPTH_X = 2
) (
    input  logic                    clk_i,
    input  logic                    resetb_i,
    input  logic                    clk_en,
    input  logic                    push,
    input  ibus_rsp_t               push_data,
    input  logic                    pop,
    output ibus_rsp_t               head,
    output logic [C_FIFO_DEPTH_X:0] count
);

    localparam int DEPTH = 2 ** C_FIFO_DEPTH_X;
    localparam logic [C_FIFO_DEPTH_X-1:0] PTR_ONE = 1;
    localparam logic [C_FIFO_DEPTH_X:0]   CNT_ONE = 1;

    ibus_rsp_t                 store [DEPTH];
    logic [C_FIFO_DEPTH_X-1:0] wr_ptr;
    logic [C_FIFO_DEPTH_X-1:0] rd_ptr;

    assign head = store[rd_ptr];

    // NOTE: storage is never reset; only the pointers and count decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (clk_en && push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clk_en) begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ibus_responder.sv
// Instruction-fetch target: word RAM with loader port, in-order responses, credit flow control.
// Accepted requests read the RAM into S1; unconsumed S1 entries spill into the response FIFO.
module ibus_responder
    import ibus_responder_pkg::*;
#(
    parameter int          C_MEM_SZX      = 10,
    parameter logic [31:0] C_BASE_ADDR    = 32'h0000_0000,
    parameter int          C_FIFO_DEPTH_X = 2,
    parameter logic [31:0] C_USER_BASE    = 32'h0000_0200
) (
    input  logic                 clk_i,
    input  logic                 resetb_i,
    input  logic                 clk_en_i,
    output logic                 ireqready_o,
    input  logic                 ireqvalid_i,
    input  logic [1:0]           ireqhpl_i,
    input  logic [31:0]          ireqaddr_i,
    input  logic                 irspready_i,
    output logic                 irspvalid_o,
    output logic                 irsprerr_o,
    output logic [31:0]          irspdata_o,
    input  logic                 ld_wr_i,
    input  logic [C_MEM_SZX-1:0] ld_addr_i,
    input  logic [31:0]          ld_data_i
);

    localparam int CW = C_FIFO_DEPTH_X + 1;
    localparam logic [CW-1:0] CNT_ONE   = 1;
    localparam logic [CW-1:0] CNT_DEPTH = CW'(2 ** C_FIFO_DEPTH_X);

    logic [31:0]          mem [2 ** C_MEM_SZX];
    logic [31:0]          rd_data;
    logic [C_MEM_SZX-1:0] req_idx;
    logic                 req_err;
    logic                 accept;
    logic                 consume;
    logic                 rdy_q;
    logic [CW-1:0]        outstanding;
    logic [CW-1:0]        outstanding_nxt;
    logic                 s1_valid;
    logic                 s1_rerr;
    ibus_rsp_t            s1_rsp;
    ibus_rsp_t            fifo_head;
    ibus_rsp_t            rsp_out;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_nonempty;
    logic                 fifo_push;
    logic                 fifo_pop;

    assign req_idx = C_MEM_SZX'((ireqaddr_i - C_BASE_ADDR) >> 2);
    assign req_err = fetch_fault(ireqaddr_i, ireqhpl_i, C_BASE_ADDR, C_USER_BASE, C_MEM_SZX);

    assign ireqready_o   = rdy_q;
    assign accept        = clk_en_i & ireqvalid_i & rdy_q;
    assign fifo_nonempty = (fifo_count != '0);
    assign irspvalid_o   = fifo_nonempty | s1_valid;
    assign consume       = clk_en_i & irspvalid_o & irspready_i;
    assign fifo_pop      = consume & fifo_nonempty;
    // S1 only drives the output when the FIFO is empty; otherwise it always spills.
    assign fifo_push     = clk_en_i & s1_valid & ~(consume & ~fifo_nonempty);

    assign s1_rsp = '{rerr: s1_rerr, data: (s1_rerr ? 32'h0 : rd_data)};

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        rsp_out = '0;
        if (fifo_nonempty) rsp_out = fifo_head;
        else if (s1_valid) rsp_out = s1_rsp;
    end

    assign irsprerr_o = rsp_out.rerr;
    assign irspdata_o = rsp_out.data;

    always_comb begin
        outstanding_nxt = outstanding;
        if (accept && !consume)      outstanding_nxt = outstanding + CNT_ONE;
        else if (!accept && consume) outstanding_nxt = outstanding - CNT_ONE;
    end

    // RAM contents survive reset; a same-edge loader write is seen only by later fetches.
    always_ff @(posedge clk_i) begin
        if (clk_en_i) begin
            if (ld_wr_i) mem[ld_addr_i] <= ld_data_i;
            if (accept)  rd_data <= mem[req_idx];
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            s1_valid    <= 1'b0;
            s1_rerr     <= 1'b0;
            outstanding <= '0;
            rdy_q       <= 1'b0;
        end else if (clk_en_i) begin
            s1_valid    <= accept;
            if (accept) s1_rerr <= req_err;
            outstanding <= outstanding_nxt;
            rdy_q       <= (outstanding_nxt < CNT_DEPTH);
        end
    end

    ibus_rsp_fifo #(
        .C_FIFO_DEPTH_X(C_FIFO_DEPTH_X)
    ) u_rsp_fifo (
        .clk_i    (clk_i),
        .resetb_i (resetb_i),
        .clk_en   (clk_en_i),
        .push     (fifo_push),
        .push_data(s1_rsp),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

endmodule
